// File: rtl/exp6_pkg.sv
// Shared definitions for the player-input stage: state encodings and default debounce length.
package exp6_pkg;

  localparam int unsigned DEBOUNCE_CICLOS_DEF = 50000;

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    FILTRA        = 3'd1,
    VALIDA        = 3'd2,
    ESPERA_SOLTAR = 3'd3,
    DESCARTA      = 3'd4
  } estado_t;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous inputs; synchronous active-low clear.
module sincronizador_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/exp6_detector_jogada.sv
// Player button conditioner: synchronise, debounce, reject multi-press, wait for release,
// then emit a registered one-hot play code with a single-cycle acceptance pulse.
module exp6_detector_jogada
  import exp6_pkg::*;
#(
  parameter int unsigned N_BOTOES        = 4,
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                habilita,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] jogada,
  output logic                jogada_feita,
  output logic                db_multiplo,
  output logic [2:0]          db_estado
);

  localparam int unsigned        CNT_W   = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

  function automatic logic um_bit_ativo(input logic [N_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - N_BOTOES'(1))) == '0);
  endfunction

  logic [N_BOTOES-1:0] bs;

  estado_t             estado_q, estado_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_BOTOES-1:0] cand_q, cand_d;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic                feita_q, feita_d;

  sincronizador_2ff #(
    .WIDTH(N_BOTOES)
  ) u_sinc (
    .clock(clock),
    .reset(reset),
    .d    (botoes),
    .q    (bs)
  );

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    jogada_d = jogada_q;
    feita_d  = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (habilita && (bs != '0)) begin
          if (um_bit_ativo(bs)) begin
            cand_d   = bs;
            cnt_d    = '0;
            estado_d = FILTRA;
          end else begin
            estado_d = DESCARTA;
          end
        end
      end
      FILTRA: begin
        // Losing the play window wins over any button activity.
        if (!habilita) begin
          cnt_d    = '0;
          estado_d = ESPERA_SOLTAR;
        end else if (bs == cand_q) begin
          if (cnt_q == CNT_MAX) begin
            estado_d = VALIDA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (bs == '0) begin
          estado_d = OCIOSO;
        end else begin
          estado_d = DESCARTA;
        end
      end
      VALIDA: begin
        jogada_d = cand_q;
        feita_d  = 1'b1;
        // Release debounce always starts from zero so a fast release still needs a full stable run.
        cnt_d    = '0;
        estado_d = ESPERA_SOLTAR;
      end
      ESPERA_SOLTAR: begin
        if (bs != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          estado_d = OCIOSO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DESCARTA: begin
        cnt_d    = '0;
        estado_d = ESPERA_SOLTAR;
      end
      default: begin
        cnt_d    = '0;
        estado_d = ESPERA_SOLTAR;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= ESPERA_SOLTAR;
      cnt_q    <= '0;
      cand_q   <= '0;
      jogada_q <= '0;
      feita_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      jogada_q <= jogada_d;
      feita_q  <= feita_d;
    end
  end

  assign jogada       = jogada_q;
  assign jogada_feita = feita_q;
  assign db_multiplo  = (estado_q == DESCARTA);
  assign db_estado    = estado_q;

endmodule

// File: tb/tb_exp6_detector_jogada.sv
// Bench for exp6_detector_jogada: directed step table plus randomised segments checked
// against a behavioural model of the button conditioner.
module tb_exp6_detector_jogada;

  localparam int unsigned NB = 4;
  localparam int unsigned D  = 4;

  localparam int P_IDLE    = 0;
  localparam int P_FILTER  = 1;
  localparam int P_ACCEPT  = 2;
  localparam int P_RELEASE = 3;
  localparam int P_REJECT  = 4;

  logic          clock;
  logic          reset;
  logic          habilita;
  logic [NB-1:0] botoes;
  logic [NB-1:0] jogada;
  logic          jogada_feita;
  logic          db_multiplo;
  logic [2:0]    db_estado;

  exp6_detector_jogada #(
    .N_BOTOES       (NB),
    .DEBOUNCE_CICLOS(D)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .habilita    (habilita),
    .botoes      (botoes),
    .jogada      (jogada),
    .jogada_feita(jogada_feita),
    .db_multiplo (db_multiplo),
    .db_estado   (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;
  int pulses = 0;

  // Model: synchroniser as a 2-deep delay line, phase of the press lifecycle, stable-run length.
  logic [NB-1:0] m_pipe[$];
  int            m_phase = P_RELEASE;
  int            m_run = 0;
  logic [NB-1:0] m_cand = '0;
  logic [NB-1:0] m_jog = '0;
  logic          m_pulse = 1'b0;

  function automatic int bits_set(input logic [NB-1:0] v);
    int n = 0;
    for (int i = 0; i < int'(NB); i++) if (v[i]) n++;
    return n;
  endfunction

  function void model_edge(input logic r, input logic h, input logic [NB-1:0] b);
    logic [NB-1:0] seen;
    if (!r) begin
      m_pipe  = {};
      m_pipe.push_back('0);
      m_pipe.push_back('0);
      m_phase = P_RELEASE;
      m_run   = 0;
      m_jog   = '0;
      m_pulse = 1'b0;
      return;
    end
    seen    = m_pipe[0];
    m_pulse = (m_phase == P_ACCEPT);
    if (m_phase == P_IDLE) begin
      if (h && bits_set(seen) == 1) begin
        m_cand = seen; m_run = 0; m_phase = P_FILTER;
      end else if (h && bits_set(seen) > 1) begin
        m_phase = P_REJECT;
      end
    end else if (m_phase == P_FILTER) begin
      if (!h) begin
        m_phase = P_RELEASE; m_run = 0;
      end else if (seen == m_cand) begin
        if (m_run + 1 >= int'(D)) m_phase = P_ACCEPT;
        else m_run++;
      end else begin
        m_phase = (seen == '0) ? P_IDLE : P_REJECT;
      end
    end else if (m_phase == P_ACCEPT) begin
      m_jog = m_cand; m_run = 0; m_phase = P_RELEASE;
    end else if (m_phase == P_RELEASE) begin
      if (seen != '0) m_run = 0;
      else if (m_run + 1 >= int'(D)) m_phase = P_IDLE;
      else m_run++;
    end else begin
      m_run = 0; m_phase = P_RELEASE;
    end
    void'(m_pipe.pop_front());
    m_pipe.push_back(b);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick(input logic r, input logic h, input logic [NB-1:0] b);
    reset    = r;
    habilita = h;
    botoes   = b;
    @(posedge clock);
    model_edge(r, h, b);
    #1;
    if (jogada_feita === 1'b1) pulses++;
    check("jogada", 32'(jogada), 32'(m_jog));
    check("jogada_feita", 32'(jogada_feita), 32'(m_pulse));
    check("db_estado", 32'(db_estado), 32'(m_phase));
    check("db_multiplo", 32'(db_multiplo), 32'(m_phase == P_REJECT));
  endtask

  typedef struct {
    logic          rst;
    logic          hab;
    logic [NB-1:0] b;
    int            n;
    int            exp_pulses;
    logic [NB-1:0] exp_jog;
    logic [2:0]    exp_est;
  } step_t;

  localparam int NSTEPS = 32;
  step_t steps[NSTEPS];

  initial begin
    reset    = 1'b0;
    habilita = 1'b0;
    botoes   = '0;
    m_pipe.push_back('0);
    m_pipe.push_back('0);

    // rst, hab, botoes, cycles, pulses, jogada, db_estado (values at end of step)
    steps[0]  = '{1'b0, 1'b0, 4'b0000,  1, 0, 4'b0000, 3'd3};
    steps[1]  = '{1'b1, 1'b0, 4'b0000,  4, 0, 4'b0000, 3'd0};
    steps[2]  = '{1'b1, 1'b1, 4'b0010,  4, 0, 4'b0000, 3'd1};
    steps[3]  = '{1'b0, 1'b1, 4'b0010,  1, 0, 4'b0000, 3'd3};
    steps[4]  = '{1'b1, 1'b1, 4'b0010, 20, 0, 4'b0000, 3'd3};
    steps[5]  = '{1'b1, 1'b1, 4'b0000,  6, 0, 4'b0000, 3'd0};
    steps[6]  = '{1'b1, 1'b1, 4'b0100,  7, 0, 4'b0000, 3'd2};
    steps[7]  = '{1'b1, 1'b1, 4'b0100,  1, 1, 4'b0100, 3'd3};
    steps[8]  = '{1'b1, 1'b1, 4'b0100,  2, 0, 4'b0100, 3'd3};
    steps[9]  = '{1'b1, 1'b1, 4'b0000,  5, 0, 4'b0100, 3'd3};
    steps[10] = '{1'b1, 1'b1, 4'b0000,  1, 0, 4'b0100, 3'd0};
    steps[11] = '{1'b1, 1'b1, 4'b0001,  2, 0, 4'b0100, 3'd0};
    steps[12] = '{1'b1, 1'b1, 4'b0000,  1, 0, 4'b0100, 3'd1};
    steps[13] = '{1'b1, 1'b1, 4'b0001,  8, 1, 4'b0001, 3'd3};
    steps[14] = '{1'b1, 1'b1, 4'b0001,  2, 0, 4'b0001, 3'd3};
    steps[15] = '{1'b1, 1'b1, 4'b0000,  6, 0, 4'b0001, 3'd0};
    steps[16] = '{1'b1, 1'b1, 4'b1001,  2, 0, 4'b0001, 3'd0};
    steps[17] = '{1'b1, 1'b1, 4'b1001,  1, 0, 4'b0001, 3'd4};
    steps[18] = '{1'b1, 1'b1, 4'b1001,  1, 0, 4'b0001, 3'd3};
    steps[19] = '{1'b1, 1'b1, 4'b1001,  4, 0, 4'b0001, 3'd3};
    steps[20] = '{1'b1, 1'b1, 4'b0000,  6, 0, 4'b0001, 3'd0};
    steps[21] = '{1'b1, 1'b1, 4'b1000,  8, 1, 4'b1000, 3'd3};
    steps[22] = '{1'b1, 1'b1, 4'b1000,  2, 0, 4'b1000, 3'd3};
    steps[23] = '{1'b1, 1'b1, 4'b0000,  6, 0, 4'b1000, 3'd0};
    steps[24] = '{1'b1, 1'b0, 4'b0010, 10, 0, 4'b1000, 3'd0};
    steps[25] = '{1'b1, 1'b1, 4'b0010,  4, 0, 4'b1000, 3'd1};
    steps[26] = '{1'b1, 1'b0, 4'b0010,  1, 0, 4'b1000, 3'd3};
    steps[27] = '{1'b1, 1'b1, 4'b0000,  6, 0, 4'b1000, 3'd0};
    steps[28] = '{1'b1, 1'b1, 4'b0001, 10, 1, 4'b0001, 3'd3};
    steps[29] = '{1'b1, 1'b1, 4'b0000,  8, 0, 4'b0001, 3'd0};
    steps[30] = '{1'b1, 1'b1, 4'b0010, 10, 1, 4'b0010, 3'd3};
    steps[31] = '{1'b1, 1'b1, 4'b0000,  8, 0, 4'b0010, 3'd0};

    for (int i = 0; i < NSTEPS; i++) begin
      pulses = 0;
      for (int c = 0; c < steps[i].n; c++) tick(steps[i].rst, steps[i].hab, steps[i].b);
      check($sformatf("step%0d_pulses", i), 32'(pulses), 32'(steps[i].exp_pulses));
      check($sformatf("step%0d_jogada", i), 32'(jogada), 32'(steps[i].exp_jog));
      check($sformatf("step%0d_estado", i), 32'(db_estado), 32'(steps[i].exp_est));
    end

    // Randomised segments: occasional reset, mostly-open play window, mixed button patterns.
    for (int s = 0; s < 300; s++) begin
      logic          r;
      logic          h;
      logic [NB-1:0] b;
      int            len;
      int            kind;
      r    = ($urandom_range(0, 40) != 0);
      h    = ($urandom_range(0, 9) != 0);
      kind = $urandom_range(0, 4);
      if (kind == 0 || kind == 1) b = '0;
      else if (kind == 4) b = NB'($urandom);
      else b = NB'(1) << $urandom_range(0, NB - 1);
      len = r ? $urandom_range(1, 12) : 1;
      for (int c = 0; c < len; c++) tick(r, h, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got no end, expected end");
    $fatal(1);
  end

endmodule
